// File: rtl/usb_ls_bus_arbiter.sv
// Registered owner of one shared low-speed USB D+/D- pair between a host port and a simulated device.
// Models the attach delay, idle-J pull-ups, drive turnaround, drive conflicts and host bus-reset detection.
module usb_ls_bus_arbiter #(
    parameter int unsigned CONNECT_DELAY_CYCLES = 1000,
    parameter int unsigned TURNAROUND_CYCLES    = 2,
    parameter int unsigned SE0_RESET_CYCLES     = 125
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        dev_attach,
    input  logic        host_dp_o,
    input  logic        host_dm_o,
    input  logic        host_oe,
    input  logic        dev_dp_o,
    input  logic        dev_dm_o,
    input  logic        dev_oe,
    output logic        host_dp_i,
    output logic        host_dm_i,
    output logic        dev_dp_i,
    output logic        dev_dm_i,
    output logic [2:0]  bus_state,
    output logic        conflict,
    output logic [15:0] conflict_cnt,
    output logic        bus_reset
);

    localparam int unsigned CONN_W = $clog2(CONNECT_DELAY_CYCLES + 1);
    localparam int unsigned TURN_W = $clog2(TURNAROUND_CYCLES + 1);
    localparam int unsigned SE0_W  = $clog2(SE0_RESET_CYCLES + 1);

    typedef enum logic [2:0] {
        ST_DETACHED = 3'd0,
        ST_IDLE     = 3'd1,
        ST_HOST_DRV = 3'd2,
        ST_DEV_DRV  = 3'd3,
        ST_TURN     = 3'd4,
        ST_CONFLICT = 3'd5
    } state_t;

    state_t              state, state_nxt;
    logic [CONN_W-1:0]   conn_cnt, conn_cnt_nxt;
    logic [TURN_W-1:0]   turn_cnt, turn_cnt_nxt;
    logic [SE0_W-1:0]    se0_cnt;
    logic                se0_fired;
    logic                se0_inc;

    // Next-state logic; detach overrides every state.
    always_comb begin
        state_nxt    = state;
        conn_cnt_nxt = conn_cnt;
        turn_cnt_nxt = '0;
        if (!dev_attach) begin
            state_nxt    = ST_DETACHED;
            conn_cnt_nxt = '0;
        end else begin
            case (state)
                ST_DETACHED: begin
                    if (conn_cnt == CONN_W'(CONNECT_DELAY_CYCLES - 1)) begin
                        state_nxt    = ST_IDLE;
                        conn_cnt_nxt = '0;
                    end else begin
                        conn_cnt_nxt = conn_cnt + CONN_W'(1);
                    end
                end
                ST_IDLE: begin
                    if (host_oe && dev_oe)  state_nxt = ST_CONFLICT;
                    else if (host_oe)       state_nxt = ST_HOST_DRV;
                    else if (dev_oe)        state_nxt = ST_DEV_DRV;
                end
                ST_HOST_DRV: begin
                    if (dev_oe)             state_nxt = ST_CONFLICT;
                    else if (!host_oe)      state_nxt = ST_TURN;
                end
                ST_DEV_DRV: begin
                    if (host_oe)            state_nxt = ST_CONFLICT;
                    else if (!dev_oe)       state_nxt = ST_TURN;
                end
                ST_TURN: begin
                    if (turn_cnt == TURN_W'(TURNAROUND_CYCLES - 1)) state_nxt = ST_IDLE;
                    else turn_cnt_nxt = turn_cnt + TURN_W'(1);
                end
                ST_CONFLICT: begin
                    if (!host_oe && !dev_oe) state_nxt = ST_TURN;
                end
                default: state_nxt = ST_DETACHED;
            endcase
        end
    end

    // SE0 run only counts while the host keeps the bus across the edge.
    assign se0_inc = (state == ST_HOST_DRV) && (state_nxt == ST_HOST_DRV) && !host_dp_o && !host_dm_o;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_DETACHED;
            conn_cnt     <= '0;
            turn_cnt     <= '0;
            se0_cnt      <= '0;
            se0_fired    <= 1'b0;
            bus_reset    <= 1'b0;
            conflict     <= 1'b0;
            conflict_cnt <= '0;
            host_dp_i    <= 1'b0;
            host_dm_i    <= 1'b0;
            dev_dp_i     <= 1'b0;
            dev_dm_i     <= 1'b0;
        end else begin
            state    <= state_nxt;
            conn_cnt <= conn_cnt_nxt;
            turn_cnt <= turn_cnt_nxt;

            bus_reset <= (se0_cnt == SE0_W'(SE0_RESET_CYCLES)) && !se0_fired;
            if (!se0_inc) begin
                se0_cnt   <= '0;
                se0_fired <= 1'b0;
            end else if (se0_cnt == SE0_W'(SE0_RESET_CYCLES)) begin
                se0_fired <= 1'b1;
            end else begin
                se0_cnt <= se0_cnt + SE0_W'(1);
            end

            conflict <= (state_nxt == ST_CONFLICT);
            if ((state_nxt == ST_CONFLICT) && (state != ST_CONFLICT) && (conflict_cnt != 16'hFFFF))
                conflict_cnt <= conflict_cnt + 16'd1;

            // Line values seen by each side: the owner sees its own pull-up J, the other sees the driver.
            case (state_nxt)
                ST_HOST_DRV: begin
                    host_dp_i <= 1'b0;       host_dm_i <= 1'b1;
                    dev_dp_i  <= host_dp_o;  dev_dm_i  <= host_dm_o;
                end
                ST_DEV_DRV: begin
                    host_dp_i <= dev_dp_o;   host_dm_i <= dev_dm_o;
                    dev_dp_i  <= 1'b0;       dev_dm_i  <= 1'b1;
                end
                ST_IDLE, ST_TURN: begin
                    host_dp_i <= 1'b0;       host_dm_i <= 1'b1;
                    dev_dp_i  <= 1'b0;       dev_dm_i  <= 1'b1;
                end
                ST_CONFLICT: begin
                    host_dp_i <= 1'b1;       host_dm_i <= 1'b1;
                    dev_dp_i  <= 1'b1;       dev_dm_i  <= 1'b1;
                end
                default: begin
                    host_dp_i <= 1'b0;       host_dm_i <= 1'b0;
                    dev_dp_i  <= 1'b0;       dev_dm_i  <= 1'b0;
                end
            endcase
        end
    end

    assign bus_state = state;

endmodule
